i2c_sniff: RTL and testbench
============================

Name: i2c_sniff

Overview:
- Parametrised, passive, listen-only I2C bus monitor. It never drives SDA or SCL, and it never ACKs or NAKs.
- Successor to the single-byte listener. Adds:
  - configurable input synchroniser and glitch filter;
  - repeated-START and STOP tagging;
  - optional 7-bit address filtering;
  - an output FIFO with a valid/ready handshake, so consumers need not catch one-cycle byte strobes;
  - overflow and framing-error reporting.
- Sits between the raw bus pins and capture/trigger logic in the glitch platform.

Parameters:
- FILT_LEN, 3: consecutive stable sysclk samples required before a filtered line changes (1..15).
- FIFO_DEPTH, 16: output FIFO entries; power of 2, minimum 2.
- CNT_W, 8: overflow counter width.

Ports:
- sysclk, input, 1: system clock; all logic is on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- sda_raw, input, 1: raw SDA pin, asynchronous.
- scl_raw, input, 1: raw SCL pin, asynchronous.
- filter_en, input, 1: 1 = pass only transactions whose address matches addr_match.
- addr_match, input, 7: target 7-bit address.
- out_data, output, 11: {first, rstart, data[7:0], ack}. ack is 1 when NAK (SDA high on the 9th bit).
- out_valid, output, 1: FIFO non-empty.
- out_ready, input, 1: consumer pop; a word is consumed when out_valid && out_ready.
- start_pulse, output, 1: one-cycle pulse on START or repeated START.
- stop_pulse, output, 1: one-cycle pulse on STOP.
- frame_err, output, 1: one-cycle pulse when START/STOP arrives with the bit count not 0.
- overflow_cnt, output, CNT_W: count of dropped words; saturates at all-ones.

Behaviour:
- Reset (asynchronous, active-high):
  - state = WAIT_IDLE; FIFO emptied; bit count 0.
  - Synchronisers and filtered lines set to 1.
  - All pulses 0; out_valid 0; out_data 0; overflow_cnt 0.
  - Reset mid-byte discards the partial byte and all FIFO contents.
- Input conditioning:
  - Each line passes through a 2-flop synchroniser, then the filter.
  - Filter rule: the filtered value takes the synchronised value only after FILT_LEN consecutive equal samples that differ from the current filtered value.
  - A shorter pulse is ignored and restarts the count.
  - Pin-to-filtered latency is 2+FILT_LEN cycles.
- Edge detection: a one-cycle registered comparison of filtered vs previous filtered value, per line.
- Bus conditions:
  - START = SDA falls while SCL is high in both the current and previous filtered samples.
  - STOP = SDA rises under the same SCL condition.
  - Data sample = SCL rising edge.
  - If SDA and SCL edges fall in the same cycle, it is a data event, not START/STOP.
- States:
  - WAIT_IDLE: go to FREE when filtered SDA=1 and SCL=1.
  - FREE: on START go to ACTIVE with first=1, rstart=0; pulse start_pulse.
  - ACTIVE:
    - On each SCL rise, shift SDA in MSB first and increment the bit count.
    - On the 9th rise, form the word and clear the count.
    - If the word has first=1 and filter_en=1 and data[7:1] != addr_match, do not push; go to SKIP.
    - Otherwise push the word; subsequent words carry first=0, rstart=0.
    - START in ACTIVE: rstart=1, first=1 for the next word; pulse start_pulse.
    - STOP in ACTIVE: go to FREE; pulse stop_pulse.
    - If the bit count is not 0 at START or STOP, pulse frame_err and discard the partial byte.
  - SKIP:
    - Ignore data.
    - START returns to ACTIVE with rstart=1, first=1.
    - STOP goes to FREE.
    - Pulses are still generated.
- filter_en and addr_match are sampled when the address word completes. Changing them mid-transaction affects only the next address byte.
- FIFO:
  - Push occurs in the cycle the 9th edge is detected. out_valid rises the next cycle if the FIFO was empty.
  - out_data is the head entry, stable while out_valid=1 and not popped.
  - Push when full with no pop: the word is dropped and overflow_cnt increments (saturating).
  - Push when full with a simultaneous pop: both succeed; there is no drop.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH, with an extra wrap bit for full/empty.

Test Plan:
- Write 0x50,0xA5 (ACK,ACK) then STOP, with out_ready=1 and filter_en=0 → words {1,0,0xA0,0} and {0,0,0xA5,0}; start_pulse then stop_pulse; frame_err=0.
- Transaction addr 0x50 W, byte 0x01, repeated START, addr 0x50 R, byte 0x3C with NAK, STOP → the 4th word is {0,0,0x3C,1} and the 3rd word has rstart=1, first=1.
- filter_en=1, addr_match=0x51; traffic to 0x50 then to 0x51 → only the 0x51 transaction's words appear; pulses occur for both transactions.
- 1-cycle and (FILT_LEN-1)-cycle SCL glitches mid-byte → no extra bits, and words are correct.
- out_ready=0 and 20 bytes sent with FIFO_DEPTH=16 → out_valid=1, overflow_cnt=4, and draining yields the first 16 bytes in order.
- STOP after 4 bits → frame_err pulse and no word pushed. Assert rst mid-byte → out_valid=0 and overflow_cnt=0 immediately; the next transaction is only captured after the bus has gone idle.

Source files
------------

// File: rtl/i2c_sniff.sv
// ============================================================================
// i2c_sniff
// ----------------------------------------------------------------------------
// Passive, listen-only I2C bus monitor. It never drives SDA or SCL and never
// acknowledges. Raw pins are synchronised and glitch filtered. START, repeated
// START and STOP are detected, and every completed 9-bit frame becomes one
// tagged word. The words pass through an optional 7-bit address filter and
// are queued in a FIFO that the consumer drains with a valid/ready handshake.
//
// Parameters
//   FILT_LEN    consecutive stable samples before a filtered line moves (1..15)
//   FIFO_DEPTH  output FIFO entries (power of 2, >= 2)
//   CNT_W       width of the saturating overflow counter
//
// Ports
//   sysclk        system clock, rising edge
//   rst           asynchronous active-high reset
//   sda_raw       raw SDA pin (asynchronous)
//   scl_raw       raw SCL pin (asynchronous)
//   filter_en     1 = keep only transactions addressed to addr_match
//   addr_match    7-bit target address
//   out_data      FIFO head: {first, rstart, data[7:0], ack}; ack=1 means NAK
//   out_valid     FIFO not empty
//   out_ready     consumer pop (word consumed when out_valid && out_ready)
//   start_pulse   one-cycle pulse on START / repeated START
//   stop_pulse    one-cycle pulse on STOP
//   frame_err     one-cycle pulse on START/STOP in the middle of a byte
//   overflow_cnt  number of words dropped because the FIFO was full
// ============================================================================
module i2c_sniff #(
    parameter int FILT_LEN   = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 8
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             sda_raw,
    input  logic             scl_raw,
    input  logic             filter_en,
    input  logic [6:0]       addr_match,
    output logic [10:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             start_pulse,
    output logic             stop_pulse,
    output logic             frame_err,
    output logic [CNT_W-1:0] overflow_cnt
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int FCW = 4;

    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);
    localparam logic [AW:0]    PTR_ONE   = (AW + 1)'(1);
    localparam logic [3:0]     LAST_DATA = 4'd8;

    localparam logic [1:0] WAIT_IDLE = 2'd0;
    localparam logic [1:0] FREE      = 2'd1;
    localparam logic [1:0] ACTIVE    = 2'd2;
    localparam logic [1:0] SKIP      = 2'd3;

    // ------------------------------------------------------------------------
    // Input conditioning. Bit 0 carries SDA, bit 1 carries SCL.
    // ------------------------------------------------------------------------
    logic [1:0]     sync1;
    logic [1:0]     sync2;
    logic [1:0]     filt;
    logic [1:0]     filt_prev;
    logic [FCW-1:0] fcnt [2];

    // The counter only runs while the synchronised sample disagrees with the
    // filtered value; any agreeing sample restarts it, so a pulse shorter
    // than FILT_LEN samples never reaches the filtered line.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            sync1     <= 2'b11;
            sync2     <= 2'b11;
            filt      <= 2'b11;
            filt_prev <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                fcnt[i] <= '0;
            end
        end else begin
            sync1     <= {scl_raw, sda_raw};
            sync2     <= sync1;
            filt_prev <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILT_LAST) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Bus conditions derived from filtered lines and their previous values.
    // ------------------------------------------------------------------------
    logic sda_f;
    logic scl_f;
    logic sda_prev;
    logic scl_prev;
    logic scl_rise;
    logic scl_high_both;
    logic start_cond;
    logic stop_cond;

    assign sda_f    = filt[0];
    assign scl_f    = filt[1];
    assign sda_prev = filt_prev[0];
    assign scl_prev = filt_prev[1];

    // Requiring SCL high in both samples means an SDA edge that coincides
    // with an SCL edge is treated as data, never as START/STOP.
    assign scl_rise      = scl_f & ~scl_prev;
    assign scl_high_both = scl_f & scl_prev;
    assign start_cond    = scl_high_both & sda_prev & ~sda_f;
    assign stop_cond     = scl_high_both & ~sda_prev & sda_f;

    // ------------------------------------------------------------------------
    // Frame assembly.
    // ------------------------------------------------------------------------
    logic [1:0]  state;
    logic [3:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        first_flag;
    logic        rstart_flag;
    logic        ninth_edge;
    logic        addr_miss;
    logic        framing_bad;
    logic        push_req;
    logic [10:0] push_word;

    // The SCL rise that sets up a START/STOP is itself counted as a bit, so
    // one counted bit is the normal framing; two or more means a byte was
    // cut short.
    always_comb begin
        ninth_edge  = (state == ACTIVE) && scl_rise && (bit_cnt == LAST_DATA);
        addr_miss   = first_flag && filter_en && (shreg[7:1] != addr_match);
        framing_bad = (bit_cnt > 4'd1);
        push_req    = ninth_edge && !addr_miss;
        push_word   = {first_flag, rstart_flag, shreg, sda_f};
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            first_flag  <= 1'b0;
            rstart_flag <= 1'b0;
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                WAIT_IDLE: begin
                    if (sda_f && scl_f) begin
                        state <= FREE;
                    end
                end
                FREE: begin
                    if (start_cond) begin
                        state       <= ACTIVE;
                        first_flag  <= 1'b1;
                        rstart_flag <= 1'b0;
                        bit_cnt     <= '0;
                        start_pulse <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (start_cond) begin
                        first_flag  <= 1'b1;
                        rstart_flag <= 1'b1;
                        bit_cnt     <= '0;
                        start_pulse <= 1'b1;
                        frame_err   <= framing_bad;
                    end else if (stop_cond) begin
                        state      <= FREE;
                        bit_cnt    <= '0;
                        stop_pulse <= 1'b1;
                        frame_err  <= framing_bad;
                    end else if (scl_rise) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (addr_miss) begin
                                state <= SKIP;
                            end else begin
                                first_flag  <= 1'b0;
                                rstart_flag <= 1'b0;
                            end
                        end else begin
                            shreg   <= {shreg[6:0], sda_f};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                SKIP: begin
                    if (start_cond) begin
                        state       <= ACTIVE;
                        first_flag  <= 1'b1;
                        rstart_flag <= 1'b1;
                        bit_cnt     <= '0;
                        start_pulse <= 1'b1;
                    end else if (stop_cond) begin
                        state      <= FREE;
                        stop_pulse <= 1'b1;
                    end
                end
                default: begin
                    state <= WAIT_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output FIFO. Pointers carry one extra wrap bit to tell full from empty.
    // ------------------------------------------------------------------------
    logic [10:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_empty;
    logic        fifo_full;
    logic        do_pop;
    logic        do_push;
    logic        drop;

    // A push into a full FIFO still fits when the head leaves in the same
    // cycle; the write lands in the slot being vacated.
    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_pop     = !fifo_empty && out_ready;
        do_push    = push_req && (!fifo_full || do_pop);
        drop       = push_req && fifo_full && !do_pop;
    end

    always_ff @(posedge sysclk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_word;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            overflow_cnt <= '0;
        end else if (drop && (overflow_cnt != {CNT_W{1'b1}})) begin
            overflow_cnt <= overflow_cnt + CNT_W'(1);
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 11'd0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_i2c_sniff.sv
// ============================================================================
// tb_i2c_sniff
// ----------------------------------------------------------------------------
// Scoreboard bench for i2c_sniff. Bus-level tasks drive the raw pins; the
// transaction tasks around them keep a transaction-level picture of the bus
// (who is addressed, which word is first after a START, how full the FIFO
// is while the consumer is stalled) and queue the words the sniffer should
// emit. A free-running monitor pops the queue whenever the DUT hands over a
// word and also counts the event pulses.
// ============================================================================
module tb_i2c_sniff;

    localparam int FILT_LEN   = 3;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 8;

    logic             sysclk = 1'b0;
    logic             rst;
    logic             sda_raw = 1'b1;
    logic             scl_raw = 1'b1;
    logic             filter_en = 1'b0;
    logic [6:0]       addr_match = 7'd0;
    logic             out_ready = 1'b1;
    logic [10:0]      out_data;
    logic             out_valid;
    logic             start_pulse;
    logic             stop_pulse;
    logic             frame_err;
    logic [CNT_W-1:0] overflow_cnt;

    i2c_sniff #(
        .FILT_LEN  (FILT_LEN),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .sda_raw     (sda_raw),
        .scl_raw     (scl_raw),
        .filter_en   (filter_en),
        .addr_match  (addr_match),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .start_pulse (start_pulse),
        .stop_pulse  (stop_pulse),
        .frame_err   (frame_err),
        .overflow_cnt(overflow_cnt)
    );

    always #5 sysclk = ~sysclk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [10:0] exp_q [$];

    // Transaction-level reference state.
    bit m_active  = 1'b0;
    bit m_skip    = 1'b0;
    bit m_first   = 1'b0;
    bit m_rstart  = 1'b0;
    int m_pending = 0;
    int hold_occ  = 0;
    int exp_ovf   = 0;
    int exp_start = 0;
    int exp_stop  = 0;
    int exp_frame = 0;
    int obs_start = 0;
    int obs_stop  = 0;
    int obs_frame = 0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Words are compared at the negative edge before the rising edge that
    // consumes them; inputs only change 1 ns after rising edges.
    always @(negedge sysclk) begin
        if (!rst) begin
            if (start_pulse) obs_start++;
            if (stop_pulse)  obs_stop++;
            if (frame_err)   obs_frame++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("[TB] FAIL unexpected_word: got 0x%0h, expected none", out_data);
                end else begin
                    check_output("fifo_word", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Raw bus drivers
    // ------------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic bus_bit(input logic b, input int glen);
        sda_raw = b;
        cyc(4);
        if (glen > 0) begin
            scl_raw = 1'b1;
            cyc(glen);
            scl_raw = 1'b0;
            cyc(4);
        end
        scl_raw = 1'b1;
        cyc(8);
        scl_raw = 1'b0;
        cyc(3);
    endtask

    task automatic bus_byte(input logic [7:0] d, input logic nak,
                            input int gbit, input int glen);
        for (int i = 7; i >= 0; i--) begin
            bus_bit(d[i], (i == gbit) ? glen : 0);
        end
        bus_bit(nak, 0);
    endtask

    task automatic bus_start();
        sda_raw = 1'b1;
        cyc(4);
        scl_raw = 1'b1;
        cyc(8);
        sda_raw = 1'b0;
        cyc(8);
        scl_raw = 1'b0;
        cyc(3);
    endtask

    task automatic bus_stop();
        sda_raw = 1'b0;
        cyc(4);
        scl_raw = 1'b1;
        cyc(8);
        sda_raw = 1'b1;
        cyc(8);
    endtask

    // ------------------------------------------------------------------------
    // Transactions with reference model
    // ------------------------------------------------------------------------
    task automatic model_push(input logic [10:0] w);
        if (!out_ready) begin
            if (hold_occ < FIFO_DEPTH) begin
                exp_q.push_back(w);
                hold_occ++;
            end else if (exp_ovf < 255) begin
                exp_ovf++;
            end
        end else begin
            exp_q.push_back(w);
        end
    endtask

    task automatic tx_start();
        if (m_active && m_pending != 0) exp_frame++;
        m_rstart  = m_active || m_skip;
        m_first   = 1'b1;
        m_active  = 1'b1;
        m_skip    = 1'b0;
        m_pending = 0;
        exp_start++;
        bus_start();
    endtask

    task automatic tx_stop();
        if (m_active && m_pending != 0) exp_frame++;
        if (m_active || m_skip) exp_stop++;
        m_active  = 1'b0;
        m_skip    = 1'b0;
        m_pending = 0;
        bus_stop();
    endtask

    task automatic tx_byte(input logic [7:0] d, input logic nak,
                           input int gbit, input int glen);
        if (m_active) begin
            if (m_first && filter_en && (d[7:1] != addr_match)) begin
                m_active = 1'b0;
                m_skip   = 1'b1;
            end else begin
                model_push({m_first, m_rstart, d, nak});
                m_first  = 1'b0;
                m_rstart = 1'b0;
            end
        end
        bus_byte(d, nak, gbit, glen);
    endtask

    task automatic tx_partial(input int nbits);
        if (m_active) m_pending = nbits;
        for (int i = 0; i < nbits; i++) begin
            bus_bit(1'($urandom_range(0, 1)), 0);
        end
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            cyc(1);
            k++;
        end
        check_output(name, 32'(exp_q.size()), 32'd0);
        cyc(4);
    endtask

    task automatic check_pulses(input string name);
        cyc(10);
        check_output({name, "_start_pulses"}, 32'(obs_start), 32'(exp_start));
        check_output({name, "_stop_pulses"},  32'(obs_stop),  32'(exp_stop));
        check_output({name, "_frame_errs"},   32'(obs_frame), 32'(exp_frame));
        obs_start = 0; obs_stop = 0; obs_frame = 0;
        exp_start = 0; exp_stop = 0; exp_frame = 0;
    endtask

    task automatic rand_byte(output logic [7:0] v);
        v = 8'($urandom_range(0, 255));
    endtask

    // One random transaction: address, a few data bytes with random ACK/NAK
    // and occasional sub-threshold SCL glitches, optional repeated START.
    task automatic apply_stimulus();
        logic [6:0] a;
        logic [6:0] a2;
        logic [7:0] d;
        int         nb;
        a  = 7'($urandom_range(0, 127));
        a2 = ($urandom_range(0, 1) == 1) ? a : 7'($urandom_range(0, 127));
        filter_en  = 1'($urandom_range(0, 1));
        addr_match = ($urandom_range(0, 1) == 1) ? a : 7'($urandom_range(0, 127));
        tx_start();
        tx_byte({a, 1'($urandom_range(0, 1))}, 1'($urandom_range(0, 1)), -1, 0);
        nb = $urandom_range(0, 3);
        for (int j = 0; j < nb; j++) begin
            rand_byte(d);
            tx_byte(d, 1'($urandom_range(0, 1)), $urandom_range(0, 8) - 1,
                    $urandom_range(1, FILT_LEN - 1));
        end
        if ($urandom_range(0, 1) == 1) begin
            tx_start();
            tx_byte({a2, 1'b1}, 1'b0, -1, 0);
            rand_byte(d);
            tx_byte(d, 1'b1, -1, 0);
        end
        tx_stop();
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        logic [7:0] d;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_output("reset_out_valid", 32'(out_valid), 32'd0);
        check_output("reset_out_data", 32'(out_data), 32'd0);
        check_output("reset_overflow_cnt", 32'(overflow_cnt), 32'd0);
        check_output("reset_pulses", 32'({start_pulse, stop_pulse, frame_err}), 32'd0);
        cyc(3);
        rst = 1'b0;
        cyc(10);

        $display("[TB] simple write 0x50: 0xA5");
        filter_en = 1'b0;
        tx_start();
        tx_byte(8'hA0, 1'b0, -1, 0);
        tx_byte(8'hA5, 1'b0, -1, 0);
        tx_stop();
        wait_drain("write_drain");
        check_pulses("write");

        $display("[TB] write, repeated START, read with NAK");
        tx_start();
        tx_byte(8'hA0, 1'b0, -1, 0);
        tx_byte(8'h01, 1'b0, -1, 0);
        tx_start();
        tx_byte(8'hA1, 1'b0, -1, 0);
        tx_byte(8'h3C, 1'b1, -1, 0);
        tx_stop();
        wait_drain("rstart_drain");
        check_pulses("rstart");

        $display("[TB] address filter 0x51");
        filter_en  = 1'b1;
        addr_match = 7'h51;
        tx_start();
        tx_byte(8'hA0, 1'b0, -1, 0);
        rand_byte(d);
        tx_byte(d, 1'b0, -1, 0);
        tx_stop();
        tx_start();
        tx_byte(8'hA2, 1'b0, -1, 0);
        rand_byte(d);
        tx_byte(d, 1'b0, -1, 0);
        rand_byte(d);
        tx_byte(d, 1'b1, -1, 0);
        tx_stop();
        wait_drain("filter_drain");
        check_pulses("filter");

        $display("[TB] SCL glitches mid-byte");
        filter_en = 1'b0;
        tx_start();
        tx_byte(8'hA0, 1'b0, 3, 1);
        rand_byte(d);
        tx_byte(d, 1'b0, 5, FILT_LEN - 1);
        rand_byte(d);
        tx_byte(d, 1'b0, 0, FILT_LEN - 1);
        tx_stop();
        wait_drain("glitch_drain");
        check_pulses("glitch");

        $display("[TB] random transactions");
        for (int t = 0; t < 8; t++) begin
            apply_stimulus();
        end
        wait_drain("random_drain");
        check_pulses("random");

        $display("[TB] framing errors");
        filter_en = 1'b0;
        tx_start();
        tx_partial(4);
        tx_stop();
        tx_start();
        tx_byte(8'hA4, 1'b0, -1, 0);
        tx_partial($urandom_range(1, 7));
        tx_start();
        tx_byte(8'hA5, 1'b0, -1, 0);
        tx_stop();
        wait_drain("frame_drain");
        check_pulses("frame");

        $display("[TB] overflow with stalled consumer");
        out_ready = 1'b0;
        hold_occ  = 0;
        tx_start();
        tx_byte(8'hA0, 1'b0, -1, 0);
        for (int i = 0; i < 19; i++) begin
            rand_byte(d);
            tx_byte(d, 1'b0, -1, 0);
        end
        tx_stop();
        cyc(10);
        check_output("ovf_out_valid", 32'(out_valid), 32'd1);
        check_output("ovf_count", 32'(overflow_cnt), 32'(exp_ovf));
        check_pulses("ovf");
        out_ready = 1'b1;
        wait_drain("ovf_drain");
        check_output("ovf_drained_valid", 32'(out_valid), 32'd0);
        check_output("ovf_drained_data", 32'(out_data), 32'd0);

        $display("[TB] reset mid-byte");
        out_ready = 1'b0;
        hold_occ  = 0;
        tx_start();
        tx_byte(8'hA0, 1'b0, -1, 0);
        for (int i = 0; i < 4; i++) bus_bit(1'($urandom_range(0, 1)), 0);
        check_output("pre_reset_out_valid", 32'(out_valid), 32'd1);
        check_output("pre_reset_overflow", 32'(overflow_cnt), 32'(exp_ovf));
        rst = 1'b1;
        #1;
        check_output("mid_reset_out_valid", 32'(out_valid), 32'd0);
        check_output("mid_reset_overflow", 32'(overflow_cnt), 32'd0);
        exp_q.delete();
        m_active = 1'b0; m_skip = 1'b0; m_pending = 0; exp_ovf = 0;
        cyc(2);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) bus_bit(1'($urandom_range(0, 1)), 0);
        bus_bit(1'b0, 0);
        rand_byte(d);
        bus_byte(d, 1'b0, -1, 0);
        bus_stop();
        cyc(10);
        obs_start = 0; obs_stop = 0; obs_frame = 0;
        exp_start = 0; exp_stop = 0; exp_frame = 0;
        tx_start();
        tx_byte(8'hA6, 1'b0, -1, 0);
        rand_byte(d);
        tx_byte(d, 1'b1, -1, 0);
        tx_stop();
        wait_drain("post_reset_drain");
        check_pulses("post_reset");
        check_output("post_reset_overflow", 32'(overflow_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #900000;
        n_vec++;
        n_miss++;
        $display("[TB] FAIL watchdog: got timeout, expected sequence completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
